imm_gen_stage: RTL and testbench

Pipelined, parametrised immediate generator between instruction decode and execute. Extracts and sign-extends the RISC-V immediate (I/S/B/U/J plus CSR zimm and shift-amount formats) to XLEN. It also precomputes the PC-relative target `pc + imm`. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so decode and execute stall independently at full throughput.

---
 rtl/imm_gen_stage.sv | 136 +++++++++++++
 tb/tb_imm_gen_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Immediate generator between decode and execute: extracts/extends the RISC-V
// immediate, precomputes pc + imm, and registers both behind a 2-entry skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_sext_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_sext_op
);

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_I     = 3'b001;
    localparam logic [2:0] OP_S     = 3'b010;
    localparam logic [2:0] OP_B     = 3'b011;
    localparam logic [2:0] OP_U     = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_ZIMM  = 3'b110;
    localparam logic [2:0] OP_SHAMT = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      op;
    } entry_t;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_full;
    entry_t          new_entry;

    logic   o_valid_reg, o_valid_next;
    logic   s_valid_reg, s_valid_next;
    entry_t o_entry_reg, o_entry_next;
    entry_t s_entry_reg, s_entry_next;

    logic accept;
    logic consume;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, in_inst[6:0]};

    // Every format is first formed as a 32-bit value; formats that are zero-extended
    // leave bit 31 clear, so widening can always replicate bit 31.
    always_comb begin
        imm32 = 32'd0;
        case (in_sext_op)
            OP_NONE:  imm32 = 32'd0;
            OP_I:     imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            OP_S:     imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            OP_B:     imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                               in_inst[30:25], in_inst[11:8], 1'b0};
            OP_U:     imm32 = {in_inst[31:12], 12'd0};
            OP_J:     imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                               in_inst[20], in_inst[30:21], 1'b0};
            OP_ZIMM:  imm32 = {27'd0, in_inst[19:15]};
            OP_SHAMT: imm32 = (XLEN == 64) ? {26'd0, in_inst[25:20]}
                                           : {27'd0, in_inst[24:20]};
            default:  imm32 = 32'd0;
        endcase
    end

    genvar gi;
    assign imm_full[31:0] = imm32;
    generate
        for (gi = 32; gi < XLEN; gi++) begin : g_sext
            assign imm_full[gi] = imm32[31];
        end
    endgenerate

    assign new_entry.imm    = imm_full;
    assign new_entry.target = in_pc + imm_full;
    assign new_entry.op     = in_sext_op;

    assign in_ready = rst_n && !s_valid_reg;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = o_valid_reg && out_ready;

    always_comb begin
        o_valid_next = o_valid_reg;
        s_valid_next = s_valid_reg;
        o_entry_next = o_entry_reg;
        s_entry_next = s_entry_reg;
        if (flush) begin
            o_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else if (!o_valid_reg || consume) begin
            if (s_valid_reg) begin
                // Skid entry is older, so it goes out first.
                o_valid_next = 1'b1;
                o_entry_next = s_entry_reg;
                s_valid_next = accept;
                if (accept) begin
                    s_entry_next = new_entry;
                end
            end else begin
                o_valid_next = accept;
                if (accept) begin
                    o_entry_next = new_entry;
                end
            end
        end else if (accept) begin
            s_valid_next = 1'b1;
            s_entry_next = new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            o_entry_reg <= '0;
            s_entry_reg <= '0;
        end else begin
            o_valid_reg <= o_valid_next;
            s_valid_reg <= s_valid_next;
            o_entry_reg <= o_entry_next;
            s_entry_reg <= s_entry_next;
        end
    end

    assign out_valid   = o_valid_reg;
    assign out_imm     = o_entry_reg.imm;
    assign out_target  = o_entry_reg.target;
    assign out_sext_op = o_entry_reg.op;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a 2-deep FIFO model plus directed literal cases.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [2:0]  in_sext_op;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        rdy32, rdy64, ov32, ov64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [2:0]  op32, op64;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
        .in_pc(pc32), .in_sext_op(in_sext_op),
        .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_target(tgt32), .out_sext_op(op32)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
        .in_pc(pc64), .in_sext_op(in_sext_op),
        .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_target(tgt64), .out_sext_op(op64)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Two's-complement interpretation of an n-bit field.
    function automatic longint sx(input longint val, input int bits);
        longint one = 1;
        return (val >= (one << (bits - 1))) ? val - (one << bits) : val;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] op,
                                             input bit is64);
        longint v;
        case (op)
            3'd1: v = sx(longint'(inst[31:20]), 12);
            3'd2: v = sx(longint'({inst[31:25], inst[11:7]}), 12);
            3'd3: v = sx(longint'({inst[31], inst[7], inst[30:25], inst[11:8]}), 12) * 2;
            3'd4: v = sx(longint'(inst[31:12]), 20) * 4096;
            3'd5: v = sx(longint'({inst[31], inst[19:12], inst[20], inst[30:21]}), 20) * 2;
            3'd6: v = longint'(inst[19:15]);
            3'd7: v = is64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    typedef struct {
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [2:0]  op;
    } entry_t;

    entry_t q[$];

    // Model: a FIFO of at most two entries; full means not ready.
    always @(posedge clk) begin
        int n;
        entry_t e;
        n = q.size();
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) begin
                e.imm64 = ref_imm(in_inst, in_sext_op, 1'b1);
                e.tgt64 = pc64 + e.imm64;
                e.imm32 = ref_imm(in_inst, in_sext_op, 1'b0);
                e.imm32 = e.imm32;
                e.tgt32 = pc32 + e.imm32;
                e.op    = in_sext_op;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            logic exp_rdy, exp_v;
            exp_rdy = rst_n && (q.size() < 2);
            exp_v   = (q.size() > 0);
            chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
            chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
            chk("out_valid32", 64'(ov32), 64'(exp_v));
            chk("out_valid64", 64'(ov64), 64'(exp_v));
            if (exp_v) begin
                chk("imm32", 64'(imm32), 64'(q[0].imm32));
                chk("tgt32", 64'(tgt32), 64'(q[0].tgt32));
                chk("op32", 64'(op32), 64'(q[0].op));
                chk("imm64", imm64, q[0].imm64);
                chk("tgt64", tgt64, q[0].tgt64);
                chk("op64", 64'(op64), 64'(q[0].op));
            end
        end
    end

    // Applies inputs now (just after an edge) and returns just after the next edge.
    task automatic put(input logic v, input logic [31:0] inst, input logic [2:0] op,
                       input logic [31:0] p32, input logic [63:0] p64,
                       input logic ordy, input logic fl);
        in_valid   = v;
        in_inst    = inst;
        in_sext_op = op;
        pc32       = p32;
        pc64       = p64;
        out_ready  = ordy;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_sext_op = 3'd0; pc32 = 32'd0; pc64 = 64'd0;

        // Pin the reference model with hand-computed values.
        chk("ref_I", ref_imm(32'hFFF00093, 3'd1, 1'b1), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ref_B", ref_imm(32'hFE000EE3, 3'd3, 1'b0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("ref_U", ref_imm(32'h800000B7, 3'd4, 1'b1), 64'hFFFF_FFFF_8000_0000);
        chk("ref_zimm", ref_imm(32'h000FD073, 3'd6, 1'b1), 64'h1F);
        chk("ref_shamt64", ref_imm(32'h03F01013, 3'd7, 1'b1), 64'h3F);
        chk("ref_shamt32", ref_imm(32'h03F01013, 3'd7, 1'b0), 64'h1F);

        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_tgt64", tgt64, 64'd0);
        chk("rst_ready", 64'(rdy32), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(rdy32), 64'd1);

        put(1, 32'hFFF00093, 3'd1, 32'h100, 64'h100, 1, 0);
        chk("I_valid", 64'(ov32), 64'd1);
        chk("I_imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("I_tgt32", 64'(tgt32), 64'h0000_00FF);
        put(1, 32'hFE000EE3, 3'd3, 32'h1000, 64'h1000, 1, 0);
        chk("B_imm32", 64'(imm32), 64'hFFFF_FFFC);
        chk("B_tgt32", 64'(tgt32), 64'h0000_0FFC);
        put(1, 32'h800000B7, 3'd4, 32'd0, 64'd0, 1, 0);
        chk("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        put(1, 32'h02000093, 3'd1, 32'hFFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0);
        chk("wrap_tgt64", tgt64, 64'h10);
        chk("wrap_tgt32", 64'(tgt32), 64'h10);
        put(1, 32'h000FD073, 3'd6, 32'd0, 64'd0, 1, 0);
        chk("zimm_imm32", 64'(imm32), 64'h1F);
        put(1, 32'h03F01013, 3'd7, 32'd0, 64'd0, 1, 0);
        chk("shamt_imm64", imm64, 64'h3F);
        chk("shamt_imm32", 64'(imm32), 64'h1F);

        // Backpressure: A held on out, B in skid, C held by source.
        put(0, 32'd0, 3'd0, 32'd0, 64'd0, 1, 0);
        put(1, 32'h00100093, 3'd1, 32'd0, 64'd0, 0, 0);
        chk("bp_A_out", 64'(imm32), 64'd1);
        chk("bp_ready_A", 64'(rdy32), 64'd1);
        put(1, 32'h00200093, 3'd1, 32'd0, 64'd0, 0, 0);
        chk("bp_ready_B", 64'(rdy32), 64'd0);
        put(1, 32'h00300093, 3'd1, 32'd0, 64'd0, 0, 0);
        chk("bp_A_hold", 64'(imm32), 64'd1);
        put(1, 32'h00300093, 3'd1, 32'd0, 64'd0, 1, 0);
        chk("bp_B_out", 64'(imm32), 64'd2);
        put(1, 32'h00300093, 3'd1, 32'd0, 64'd0, 1, 0);
        chk("bp_C_out", 64'(imm32), 64'd3);
        put(0, 32'd0, 3'd0, 32'd0, 64'd0, 1, 0);
        chk("bp_drained", 64'(ov32), 64'd0);

        // Flush with both registers full, then with only O full.
        put(1, 32'h00100093, 3'd1, 32'd0, 64'd0, 0, 0);
        put(1, 32'h00200093, 3'd1, 32'd0, 64'd0, 0, 0);
        put(1, 32'h00400093, 3'd1, 32'd0, 64'd0, 0, 1);
        chk("fl_valid", 64'(ov32), 64'd0);
        chk("fl_ready", 64'(rdy32), 64'd1);
        put(1, 32'h00100093, 3'd1, 32'd0, 64'd0, 0, 0);
        put(1, 32'h00400093, 3'd1, 32'd0, 64'd0, 0, 1);
        chk("fl_D_dropped", 64'(ov64), 64'd0);
        put(0, 32'd0, 3'd0, 32'd0, 64'd0, 1, 0);
        chk("fl_D_never", 64'(ov32), 64'd0);

        // Reset mid-stream.
        put(1, 32'h00100093, 3'd1, 32'h40, 64'h40, 0, 0);
        put(1, 32'h00200093, 3'd1, 32'h40, 64'h40, 0, 0);
        rst_n = 1'b0;
        put(1, 32'h00300093, 3'd1, 32'h40, 64'h40, 0, 0);
        chk("rst_mid_valid", 64'(ov32), 64'd0);
        chk("rst_mid_imm", 64'(imm32), 64'd0);
        chk("rst_mid_tgt", 64'(tgt32), 64'd0);
        chk("rst_mid_op", 64'(op64), 64'd0);
        chk("rst_mid_ready", 64'(rdy64), 64'd0);
        rst_n = 1'b1;
        put(0, 32'd0, 3'd0, 32'd0, 64'd0, 1, 0);
        chk("rst_rel_ready", 64'(rdy32), 64'd1);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            put(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                $urandom, {$urandom, $urandom},
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
        rst_n = 1'b1;
        put(0, 32'd0, 3'd0, 32'd0, 64'd0, 1, 0);
        put(0, 32'd0, 3'd0, 32'd0, 64'd0, 1, 0);

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
